siso_shift_ctrl: RTL

SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

---
 rtl/siso_pkg.sv | 22 ++
 rtl/siso_load_shreg.sv | 29 ++
 rtl/siso_shift_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/siso_pkg.sv
// Shared state encoding, default sizes and counter sizing helper for the SISO shift controller.
// PAR is only reachable when SISO_SHIFT_CTRL_PARITY_EN is defined.
package siso_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Bits needed to count up to max(width, depth)-1, never less than one.
  function automatic int cnt_width(input int width, input int depth);
    int m;
    m = (width > depth) ? width : depth;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/siso_load_shreg.sv
// Parallel-load shift register presenting its MSB; shifts toward the MSB one bit per enabled cycle.
module siso_load_shreg
  import siso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/siso_shift_ctrl.sv
// Two-requester round-robin serializer feeding a DEPTH-stage DFF chain, then flushing it.
// Optional even-parity bit after the payload when SISO_SHIFT_CTRL_PARITY_EN is defined.
module siso_shift_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             gnt_id,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH, DEPTH);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(DEPTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last_gnt;
  logic            shift_phase;
  logic            msb;
  logic            sel;
  logic            accept;
  logic [WIDTH-1:0] sel_data;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
  logic            par_phase;
  logic            par_bit;
`endif

  // Ready is gated by rst_n so no requester sees a handshake while reset is held.
  always_comb begin
    sel      = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
    accept   = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    sel_data = sel ? req1_data : req0_data;
  end

  assign req0_ready = accept & ~sel;
  assign req1_ready = accept & sel;

  siso_load_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .shift(shift_phase),
    .data (sel_data),
    .msb  (msb)
  );

`ifdef SISO_SHIFT_CTRL_PARITY_EN
  assign ser_out = (shift_phase & msb) | (par_phase & par_bit);
`else
  assign ser_out = shift_phase & msb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_gnt    <= 1'b1;
      gnt_id      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ser_en      <= 1'b0;
      shift_phase <= 1'b0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
      par_phase   <= 1'b0;
      par_bit     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state       <= SHIFT;
            cnt         <= '0;
            gnt_id      <= sel;
            last_gnt    <= sel;
            busy        <= 1'b1;
            ser_en      <= 1'b1;
            shift_phase <= 1'b1;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            par_bit     <= ^sel_data;
`endif
          end
        end
        SHIFT: begin
          if (cnt == LAST_SHIFT) begin
            cnt         <= '0;
            shift_phase <= 1'b0;
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            state       <= PAR;
            par_phase   <= 1'b1;
`else
            state       <= FLUSH;
            ser_en      <= 1'b0;
            done        <= (LAST_FLUSH == '0);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
        PAR: begin
          state     <= FLUSH;
          par_phase <= 1'b0;
          ser_en    <= 1'b0;
          done      <= (LAST_FLUSH == '0);
        end
`endif
        // done is raised on the edge entering the final flush cycle so it is registered.
        FLUSH: begin
          if (cnt == LAST_FLUSH) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            cnt  <= cnt + CW'(1);
            done <= ((cnt + CW'(1)) == LAST_FLUSH);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
